board_dump_tx: RTL and testbench
================================

# board_dump_tx

Board readout transmitter for the ultimate tic-tac-toe datapath. On a start pulse it scans all 81 cells of the board RAM, in macro-major then micro order, through the RAM's read address ports. It encodes each cell as an ASCII byte and streams an 84-byte frame over a valid/ready byte interface toward the serial transmitter. It is the reader side of the board memory that the play datapath writes.

## Interface

- `RAM_LAT`, default 1: cycles from a stable read address to valid `estado_micro`. 0 means combinational read.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start request; sampled on the rising edge.
- `jogador_atual`  in  2  current player; snapshotted at start.
- `estado_jogo`  in  2  global game result; snapshotted at start.
- `estado_micro`  in  2  board RAM read data for (`addr_macro`, `addr_micro`).
- `addr_macro`  out  4  macro cell read address, 0..8, registered.
- `addr_micro`  out  4  micro cell read address, 0..8, registered.
- `tx_dado`  out  8  frame byte, registered.
- `tx_valido`  out  1  `tx_dado` is valid.
- `tx_pronto`  in  1  sink accepts; a transfer occurs on an edge where `tx_valido` and `tx_pronto` are both 1.
- `ocupado`  out  1  a frame is in progress.
- `concluido`  out  1  one-cycle pulse after the final byte transfers.

## Operation

- Frame, 84 bytes, in this order:
  - header 8'hA5;
  - 81 cell bytes for macro m = 0..8, and within each m, micro u = 0..8;
  - status byte 8'h30 + {jogador_snap, estado_snap} (4-bit value);
  - terminator 8'h0A.
- Cell encoding:
  - 2'b00 → 8'h2E '.'
  - 2'b01 → 8'h58 'X'
  - 2'b10 → 8'h4F 'O'
  - 2'b11 → 8'h23 '#'
- FSM states: OCIOSO, CABECALHO, ENDERECA, CELULA, STATUS, FIM_LINHA.
  - OCIOSO + `iniciar` → CABECALHO. At the same edge, snapshot `jogador_atual` and `estado_jogo`, and clear both address registers to 0.
  - CABECALHO: `tx_dado` = A5 with `tx_valido` = 1. On transfer → ENDERECA.
  - ENDERECA: addresses stable, `tx_valido` = 0, wait counter runs RAM_LAT+1 cycles. On the edge ending the last cycle, capture the encoded `estado_micro` into `tx_dado`, raise `tx_valido`, and go to CELULA.
  - CELULA: hold `tx_dado` and the addresses until transfer.
    - On transfer with (m,u) ≠ (8,8): increment u. When u wraps 8→0, increment m. Go to ENDERECA.
    - On transfer with (m,u) = (8,8): go to STATUS.
  - STATUS: present the status byte; on transfer → FIM_LINHA.
  - FIM_LINHA: present 0A. On transfer → OCIOSO, pulse `concluido` for one cycle, and return the addresses to 0.
- Flow control:
  - `tx_dado` is stable while `tx_valido` is 1 and no transfer has occurred.
  - `tx_valido` never drops without a transfer.
- `iniciar` while `ocupado` = 1 is ignored; it is not queued.
- `ocupado` = 1 in every state except OCIOSO.
- Board changes mid-frame are not blocked: each cell is read at its own ENDERECA time. Status reflects the start snapshot.

## Timing

- Reset values: `addr_macro` = 0, `addr_micro` = 0, `tx_dado` = 8'h00, `tx_valido` = 0, `ocupado` = 0, `concluido` = 0, state OCIOSO, snapshots 0.
- Asserting `reset` mid-frame returns the block to reset values immediately. The frame is abandoned and `concluido` does not pulse.
- `iniciar` sampled at edge k → `tx_valido` = 1 with A5 during cycle k+1, and `ocupado` = 1 from cycle k+1.
- With `tx_pronto` held at 1, each cell costs RAM_LAT+2 cycles. At RAM_LAT = 1:
  - frame = 1 + 243 + 1 + 1 = 246 cycles from A5 valid to 0A transfer;
  - `concluido` is high in cycle 247;
  - a new `iniciar` is accepted at the edge ending cycle 247, the first cycle back in OCIOSO.
- Address registers update only on the edge at which a cell byte transfers.

## Test plan

- Reset: drive `reset` low at random times, including mid-frame → all outputs read reset values in the next sample; release, then `iniciar` → a clean frame starting with A5.
- Full dump, RAM_LAT = 1, RAM model preloaded with cell(m,u) = (m+u)%4, `tx_pronto` = 1 → exactly 84 bytes. Bytes 1..81 match the encoding in order; for example byte 1 = '.', byte 2 = 'X', byte 81 (m = 8, u = 8, value 0) = '.'. Duration 246 cycles, then one `concluido` pulse.
- Status encoding: `jogador_atual` = 2'b10 and `estado_jogo` = 2'b01 at start, both changed to 0 one cycle later → byte 82 = 8'h39, byte 83 = 8'h0A.
- Backpressure: random `tx_pronto` at 30% duty → `tx_dado` and the addresses are stable while unaccepted, no byte is lost or duplicated, and the byte sequence is identical to the previous scenario.
- `iniciar` pulsed at cycles 5, 100 and 245 during a frame → no restart and one frame only. `iniciar` in the cycle after `concluido` → a second full frame.
- RAM_LAT = 0 and RAM_LAT = 2 builds: the captured cell data is correct for a RAM model with the matching latency. Per-cell cost is 2 and 4 cycles respectively.

Source files
------------

// File: rtl/board_dump_tx.sv
// board_dump_tx
// Streams the 81-cell ultimate tic-tac-toe board as an 84-byte ASCII frame.
// The frame is: header A5, then the 81 cells (macro-major, micro-minor), then
// a status byte, then the terminator 0A. Each cell is fetched through the
// board RAM read ports, encoded, and offered on a valid/ready byte interface.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   iniciar        start request (ignored while ocupado)
//   jogador_atual  current player, snapshotted at start
//   estado_jogo    global game result, snapshotted at start
//   estado_micro   board RAM read data for (addr_macro, addr_micro)
//   addr_macro     macro cell read address 0..8
//   addr_micro     micro cell read address 0..8
//   tx_dado        frame byte
//   tx_valido      tx_dado is valid
//   tx_pronto      sink accepts tx_dado
//   ocupado        frame in progress
//   concluido      one-cycle pulse after the terminator is accepted
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OCIOSO    | idle, waiting for iniciar
// CABECALHO | offering header A5
// ENDERECA  | address stable, waiting RAM_LAT+1 cycles for read data
// CELULA    | offering the encoded cell byte
// STATUS    | offering 0x30 + {player, game result} from the snapshot
// FIM_LINHA | offering terminator 0A
module board_dump_tx #(
  parameter int RAM_LAT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] jogador_atual,
  input  logic [1:0] estado_jogo,
  input  logic [1:0] estado_micro,
  output logic [3:0] addr_macro,
  output logic [3:0] addr_micro,
  output logic [7:0] tx_dado,
  output logic       tx_valido,
  input  logic       tx_pronto,
  output logic       ocupado,
  output logic       concluido
);

  typedef enum logic [2:0] {
    OCIOSO,
    CABECALHO,
    ENDERECA,
    CELULA,
    STATUS,
    FIM_LINHA
  } estado_t;

  localparam int CW = (RAM_LAT > 0) ? $clog2(RAM_LAT + 1) : 1;
  localparam logic [CW-1:0] ESPERA_INI = CW'(RAM_LAT);

  estado_t       estado, prox;
  logic [CW-1:0] espera;
  logic [1:0]    jog_snap, est_snap;
  logic          transf, ultima_celula, espera_fim;

  assign transf        = tx_valido & tx_pronto;
  assign ultima_celula = (addr_macro == 4'd8) && (addr_micro == 4'd8);
  assign espera_fim    = (espera == '0);
  assign ocupado       = (estado != OCIOSO);

  function automatic logic [7:0] codifica(input logic [1:0] v);
    logic [7:0] c;
    case (v)
      2'b00:   c = 8'h2E;
      2'b01:   c = 8'h58;
      2'b10:   c = 8'h4F;
      default: c = 8'h23;
    endcase
    return c;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:    if (iniciar)    prox = CABECALHO;
      CABECALHO: if (transf)     prox = ENDERECA;
      ENDERECA:  if (espera_fim) prox = CELULA;
      CELULA:    if (transf)     prox = ultima_celula ? STATUS : ENDERECA;
      STATUS:    if (transf)     prox = FIM_LINHA;
      FIM_LINHA: if (transf)     prox = OCIOSO;
      default:                   prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_macro <= 4'd0;
      addr_micro <= 4'd0;
      tx_dado    <= 8'h00;
      tx_valido  <= 1'b0;
      concluido  <= 1'b0;
      espera     <= '0;
      jog_snap   <= 2'b00;
      est_snap   <= 2'b00;
    end else begin
      concluido <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            jog_snap   <= jogador_atual;
            est_snap   <= estado_jogo;
            addr_macro <= 4'd0;
            addr_micro <= 4'd0;
            tx_dado    <= 8'hA5;
            tx_valido  <= 1'b1;
          end
        end
        CABECALHO: begin
          if (transf) begin
            tx_valido <= 1'b0;
            espera    <= ESPERA_INI;
          end
        end
        ENDERECA: begin
          // Read data is sampled on the edge closing the last wait cycle.
          if (espera_fim) begin
            tx_dado   <= codifica(estado_micro);
            tx_valido <= 1'b1;
          end else begin
            espera <= espera - CW'(1);
          end
        end
        CELULA: begin
          if (transf) begin
            if (ultima_celula) begin
              tx_dado <= 8'h30 + {4'h0, jog_snap, est_snap};
            end else begin
              tx_valido <= 1'b0;
              espera    <= ESPERA_INI;
              if (addr_micro == 4'd8) begin
                addr_micro <= 4'd0;
                addr_macro <= addr_macro + 4'd1;
              end else begin
                addr_micro <= addr_micro + 4'd1;
              end
            end
          end
        end
        STATUS: begin
          if (transf) tx_dado <= 8'h0A;
        end
        FIM_LINHA: begin
          if (transf) begin
            tx_valido  <= 1'b0;
            concluido  <= 1'b1;
            addr_macro <= 4'd0;
            addr_micro <= 4'd0;
          end
        end
        default: tx_valido <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_board_dump_tx.sv
// Testbench for board_dump_tx: three instances at RAM_LAT = 0, 1, 2, each with
// a board RAM model of matching read latency. Expected frame bytes are pushed
// to a queue when a frame is started and popped as the DUT transfers bytes.
module tb_board_dump_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ini [3];
  logic       pr  [3];
  logic [1:0] jog, est;
  logic [3:0] am  [3];
  logic [3:0] um  [3];
  logic [7:0] td  [3];
  logic       tv  [3];
  logic       oc  [3];
  logic       co  [3];

  logic [1:0] bmem [81];
  logic [7:0] exp_q [$];
  logic [7:0] got     [84];
  logic [7:0] ref_seq [84];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [1:0] rd_comb, rd;
    always_comb begin
      rd_comb = 2'b00;
      if (am[g] < 4'd9 && um[g] < 4'd9) rd_comb = bmem[int'(am[g]) * 9 + int'(um[g])];
    end
    if (g == 0) begin : g_l0
      assign rd = rd_comb;
    end else if (g == 1) begin : g_l1
      always_ff @(posedge clk) rd <= rd_comb;
    end else begin : g_l2
      logic [1:0] s1;
      always_ff @(posedge clk) begin
        s1 <= rd_comb;
        rd <= s1;
      end
    end
    board_dump_tx #(.RAM_LAT(g)) dut (
      .clock        (clk),
      .reset        (rst_n),
      .iniciar      (ini[g]),
      .jogador_atual(jog),
      .estado_jogo  (est),
      .estado_micro (rd),
      .addr_macro   (am[g]),
      .addr_micro   (um[g]),
      .tx_dado      (td[g]),
      .tx_valido    (tv[g]),
      .tx_pronto    (pr[g]),
      .ocupado      (oc[g]),
      .concluido    (co[g])
    );
  end

  function automatic logic [7:0] enc(input logic [1:0] v);
    case (v)
      2'b00:   return 8'h2E;
      2'b01:   return 8'h58;
      2'b10:   return 8'h4F;
      default: return 8'h23;
    endcase
  endfunction

  task automatic push_frame();
    exp_q.push_back(8'hA5);
    for (int m = 0; m < 9; m++)
      for (int u = 0; u < 9; u++)
        exp_q.push_back(enc(bmem[m * 9 + u]));
    exp_q.push_back(8'h30 + {4'h0, jog, est});
    exp_q.push_back(8'h0A);
  endtask

  // Called just after a rising edge; returns #1 into the first frame cycle.
  task automatic start_frame(input int idx);
    push_frame();
    ini[idx] = 1'b1;
    @(posedge clk); #1;
    ini[idx] = 1'b0;
  endtask

  task automatic collect_frame(input int idx, input int duty, input int p0, input int p1,
                               input int p2, output int cycles, output int nbytes);
    logic       hold;
    logic [7:0] pd, e;
    logic [3:0] pa, pu;
    hold = 1'b0; pd = '0; pa = '0; pu = '0;
    cycles = 0; nbytes = 0;
    while (nbytes < 84 && cycles < 2000) begin
      cycles++;
      pr[idx]  = (int'($urandom_range(99)) < duty);
      ini[idx] = (cycles == p0 || cycles == p1 || cycles == p2);
      @(negedge clk);
      n_cmp++;
      if (oc[idx] !== 1'b1 || co[idx] !== 1'b0) begin
        n_err++;
        $display("FAIL busy inst%0d cyc%0d: ocupado=%b concluido=%b, want 1/0", idx, cycles, oc[idx], co[idx]);
      end
      if (hold) begin
        n_cmp++;
        if (tv[idx] !== 1'b1 || td[idx] !== pd || am[idx] !== pa || um[idx] !== pu) begin
          n_err++;
          $display("FAIL hold inst%0d cyc%0d: v=%b d=%h a=%0d/%0d, want v=1 d=%h a=%0d/%0d",
                   idx, cycles, tv[idx], td[idx], am[idx], um[idx], pd, pa, pu);
        end
      end
      if (tv[idx] && pr[idx]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_byte inst%0d: got %h, want none", idx, td[idx]);
        end else begin
          e = exp_q.pop_front();
          if (td[idx] !== e) begin
            n_err++;
            $display("FAIL byte%0d inst%0d: got %h, want %h", nbytes, idx, td[idx], e);
          end
        end
        got[nbytes] = td[idx];
        nbytes++;
      end
      hold = tv[idx] && !pr[idx];
      pd = td[idx]; pa = am[idx]; pu = um[idx];
      @(posedge clk); #1;
    end
    pr[idx]  = 1'b0;
    ini[idx] = 1'b0;
    n_cmp++;
    if (nbytes < 84) begin
      n_err++;
      $display("FAIL timeout inst%0d: got %0d bytes, want 84", idx, nbytes);
    end
    n_cmp++;
    if (co[idx] !== 1'b1 || oc[idx] !== 1'b0 || tv[idx] !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse inst%0d: concluido=%b ocupado=%b valido=%b, want 1/0/0",
               idx, co[idx], oc[idx], tv[idx]);
    end
  endtask

  task automatic test_reset();
    int cyc, nb, d;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (am[i] !== 4'd0 || um[i] !== 4'd0 || td[i] !== 8'h00 || tv[i] !== 1'b0 ||
          oc[i] !== 1'b0 || co[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_init inst%0d: a=%0d/%0d d=%h v=%b o=%b c=%b, want all 0",
                 i, am[i], um[i], td[i], tv[i], oc[i], co[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_frame(1);
      d = int'($urandom_range(240));
      pr[1] = 1'b1;
      repeat (d) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (am[1] !== 4'd0 || um[1] !== 4'd0 || td[1] !== 8'h00 || tv[1] !== 1'b0 ||
          oc[1] !== 1'b0 || co[1] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid after %0d: a=%0d/%0d d=%h v=%b o=%b c=%b, want all 0",
                 d, am[1], um[1], td[1], tv[1], oc[1], co[1]);
      end
      pr[1] = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (co[1] !== 1'b0 || oc[1] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release: concluido=%b ocupado=%b, want 0/0", co[1], oc[1]);
      end
    end
    start_frame(1);
    collect_frame(1, 100, 0, 0, 0, cyc, nb);
    n_cmp++;
    if (got[0] !== 8'hA5) begin
      n_err++;
      $display("FAIL reset_clean_header: got %h, want a5", got[0]);
    end
  endtask

  task automatic test_full_dump();
    int cyc, nb;
    jog = 2'b00; est = 2'b00;
    start_frame(1);
    collect_frame(1, 100, 0, 0, 0, cyc, nb);
    n_cmp++;
    if (cyc !== 246) begin n_err++; $display("FAIL dump_cycles: got %0d, want 246", cyc); end
    n_cmp++;
    if (got[1] !== 8'h2E || got[2] !== 8'h58 || got[81] !== 8'h2E || got[83] !== 8'h0A) begin
      n_err++;
      $display("FAIL dump_samples: got %h %h %h %h, want 2e 58 2e 0a", got[1], got[2], got[81], got[83]);
    end
    ref_seq = got;
  endtask

  task automatic test_status();
    int cyc, nb;
    jog = 2'b10; est = 2'b01;
    start_frame(1);
    jog = 2'b00; est = 2'b00;
    collect_frame(1, 100, 0, 0, 0, cyc, nb);
    n_cmp++;
    if (got[82] !== 8'h39 || got[83] !== 8'h0A) begin
      n_err++;
      $display("FAIL status_byte: got %h %h, want 39 0a", got[82], got[83]);
    end
  endtask

  task automatic test_backpressure();
    int cyc, nb;
    jog = 2'b00; est = 2'b00;
    start_frame(1);
    collect_frame(1, 30, 0, 0, 0, cyc, nb);
    for (int i = 0; i < 84; i++) begin
      n_cmp++;
      if (got[i] !== ref_seq[i]) begin
        n_err++;
        $display("FAIL bp_seq byte%0d: got %h, want %h", i, got[i], ref_seq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    jog = 2'b00; est = 2'b00;
    start_frame(1);
    collect_frame(1, 100, 5, 100, 245, cyc, nb);
    n_cmp++;
    if (cyc !== 246) begin n_err++; $display("FAIL ignore_cycles: got %0d, want 246", cyc); end
    start_frame(1);
    collect_frame(1, 100, 0, 0, 0, cyc, nb);
    n_cmp++;
    if (cyc !== 246) begin n_err++; $display("FAIL second_cycles: got %0d, want 246", cyc); end
    repeat (10) begin
      @(posedge clk); #1;
      n_cmp++;
      if (oc[1] !== 1'b0 || tv[1] !== 1'b0 || co[1] !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after: ocupado=%b valido=%b concluido=%b, want 0/0/0", oc[1], tv[1], co[1]);
      end
    end
  endtask

  task automatic test_ram_latency();
    int cyc, nb;
    jog = 2'b00; est = 2'b00;
    for (int idx = 0; idx < 3; idx += 2) begin
      start_frame(idx);
      collect_frame(idx, 100, 0, 0, 0, cyc, nb);
      n_cmp++;
      if (cyc !== 3 + 81 * (idx + 2)) begin
        n_err++;
        $display("FAIL lat%0d_cycles: got %0d, want %0d", idx, cyc, 3 + 81 * (idx + 2));
      end
      for (int i = 0; i < 84; i++) begin
        n_cmp++;
        if (got[i] !== ref_seq[i]) begin
          n_err++;
          $display("FAIL lat%0d_seq byte%0d: got %h, want %h", idx, i, got[i], ref_seq[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin ini[i] = 1'b0; pr[i] = 1'b0; end
    jog = 2'b00; est = 2'b00;
    for (int m = 0; m < 9; m++)
      for (int u = 0; u < 9; u++)
        bmem[m * 9 + u] = 2'((m + u) % 4);
    test_reset();
    test_full_dump();
    test_status();
    test_backpressure();
    test_back_to_back();
    test_ram_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
